// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver. It synchronizes and glitch-filters the keyboard pins,
// assembles 11-bit frames, and decodes the E0/F0 prefixes. It drives a held-key
// bitmap for the game controls and a per-code strobe.
module ps2_key_decoder #(
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT    = 200000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       PS2_clk,
   input  logic       PS2_data,
   output logic [4:0] key_pressed,
   output logic [7:0] scan_code,
   output logic       scan_ext,
   output logic       scan_break,
   output logic       scan_valid,
   output logic       frame_err
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
   logic          r_filt, r_filt_d;
   logic [FW-1:0] r_fcnt;
   logic [TW-1:0] r_wdog;
   logic [3:0]    r_bitcnt;
   logic [7:0]    r_shift;
   logic          r_par, r_ext, r_brk;
   logic          w_fall, w_tmo;
   logic [4:0]    w_hit;

   // Two-flop synchronizers. They idle high so that leaving reset cannot look like an edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_clk_s1 <= 1'b1;
         r_clk_s2 <= 1'b1;
         r_dat_s1 <= 1'b1;
         r_dat_s2 <= 1'b1;
      end else begin
         r_clk_s1 <= PS2_clk;
         r_clk_s2 <= r_clk_s1;
         r_dat_s1 <= PS2_data;
         r_dat_s2 <= r_dat_s1;
      end
   end

   // Glitch filter: accept a new clock level only after FILTER_LEN equal samples.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_filt   <= 1'b1;
         r_filt_d <= 1'b1;
         r_fcnt   <= '0;
      end else begin
         r_filt_d <= r_filt;
         if (r_clk_s2 == r_filt) begin
            r_fcnt <= '0;
         end else if (r_fcnt == FW'(FILTER_LEN - 1)) begin
            r_filt <= r_clk_s2;
            r_fcnt <= '0;
         end else begin
            r_fcnt <= r_fcnt + 1'b1;
         end
      end
   end

   assign w_fall = r_filt_d & ~r_filt;
   assign w_tmo  = ~w_fall && (r_bitcnt != 4'd0) && (r_wdog == TW'(TIMEOUT - 1));

   // Watchdog runs only inside a partial frame; each keyboard clock edge restarts it.
   always_ff @(posedge clk) begin
      if (reset || w_fall || w_tmo || r_bitcnt == 4'd0) r_wdog <= '0;
      else                                              r_wdog <= r_wdog + 1'b1;
   end

   // Map (ext, code) of the completed byte onto a key bit.
   always_comb begin
      w_hit = 5'b0;
      if ( r_ext && r_shift == 8'h6B) w_hit[0] = 1'b1;
      if ( r_ext && r_shift == 8'h74) w_hit[1] = 1'b1;
      if (!r_ext && r_shift == 8'h29) w_hit[2] = 1'b1;
      if (!r_ext && r_shift == 8'h1C) w_hit[3] = 1'b1;
      if (!r_ext && r_shift == 8'h23) w_hit[4] = 1'b1;
   end

   // Frame receiver, prefix tracking and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_bitcnt    <= 4'd0;
         r_shift     <= 8'h00;
         r_par       <= 1'b0;
         r_ext       <= 1'b0;
         r_brk       <= 1'b0;
         key_pressed <= 5'b0;
         scan_code   <= 8'h00;
         scan_ext    <= 1'b0;
         scan_break  <= 1'b0;
         scan_valid  <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         scan_valid <= 1'b0;
         frame_err  <= 1'b0;
         if (w_fall) begin
            case (r_bitcnt)
               4'd0: begin
                  if (r_dat_s2) begin
                     frame_err <= 1'b1;
                  end else begin
                     r_bitcnt <= 4'd1;
                     r_par    <= 1'b0;
                  end
               end
               4'd9: begin
                  r_par    <= r_par ^ r_dat_s2;
                  r_bitcnt <= 4'd10;
               end
               4'd10: begin
                  r_bitcnt <= 4'd0;
                  if (r_par && r_dat_s2) begin
                     if (r_shift == 8'hE0) begin
                        r_ext <= 1'b1;
                     end else if (r_shift == 8'hF0) begin
                        r_brk <= 1'b1;
                     end else begin
                        scan_code   <= r_shift;
                        scan_ext    <= r_ext;
                        scan_break  <= r_brk;
                        scan_valid  <= 1'b1;
                        key_pressed <= r_brk ? (key_pressed & ~w_hit) : (key_pressed | w_hit);
                        r_ext       <= 1'b0;
                        r_brk       <= 1'b0;
                     end
                  end else begin
                     frame_err <= 1'b1;
                     r_ext     <= 1'b0;
                     r_brk     <= 1'b0;
                  end
               end
               default: begin
                  r_shift  <= {r_dat_s2, r_shift[7:1]};
                  r_par    <= r_par ^ r_dat_s2;
                  r_bitcnt <= r_bitcnt + 4'd1;
               end
            endcase
         end else if (w_tmo) begin
            r_bitcnt  <= 4'd0;
            r_ext     <= 1'b0;
            r_brk     <= 1'b0;
            frame_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: the stimulus pushes expected strobes,
// and a monitor pops them and compares them against the outputs.
module tb_ps2_key_decoder;

   localparam int FL   = 8;
   localparam int TMO  = 1000;
   localparam int HALF = 20;

   logic       clk = 1'b0, reset = 1'b1, PS2_clk = 1'b1, PS2_data = 1'b1;
   logic [4:0] key_pressed;
   logic [7:0] scan_code;
   logic       scan_ext, scan_break, scan_valid, frame_err;

   ps2_key_decoder #(.FILTER_LEN(FL), .TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset), .PS2_clk(PS2_clk), .PS2_data(PS2_data),
      .key_pressed(key_pressed), .scan_code(scan_code), .scan_ext(scan_ext),
      .scan_break(scan_break), .scan_valid(scan_valid), .frame_err(frame_err));

   always #5 clk = ~clk;

   typedef struct {
      bit         is_err;
      logic [7:0] code;
      bit         ext, brk;
      logic [4:0] keys;
      int         stop_cyc;
   } exp_t;

   exp_t       q[$];
   int         cyc = 0;
   int         n_checks = 0, n_pass = 0;
   bit         m_ext = 0, m_brk = 0;
   logic [4:0] m_keys = 5'b0;
   logic [7:0] kcode [5] = '{8'h6B, 8'h74, 8'h29, 8'h1C, 8'h23};
   bit         kext  [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Reference model: a byte stream interpreted by the prefix rules.
   task automatic model_byte(logic [7:0] b, int stop_cyc);
      exp_t e;
      if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else begin
         for (int k = 0; k < 5; k++)
            if (kcode[k] == b && kext[k] == m_ext) m_keys[k] = !m_brk;
         e.is_err = 0; e.code = b; e.ext = m_ext; e.brk = m_brk;
         e.keys = m_keys; e.stop_cyc = stop_cyc;
         q.push_back(e);
         m_ext = 0; m_brk = 0;
      end
   endtask

   task automatic model_err(bit clr_flags);
      exp_t e;
      e.is_err = 1; e.code = 0; e.ext = 0; e.brk = 0; e.keys = m_keys; e.stop_cyc = -1;
      q.push_back(e);
      if (clr_flags) begin m_ext = 0; m_brk = 0; end
   endtask

   // One keyboard clock period. The data is set while the clock is high, and the model is updated at the stop-bit fall.
   task automatic drive_bit(bit d, bit last, logic [7:0] b, bit ok);
      PS2_data = d;
      repeat (HALF) @(negedge clk);
      PS2_clk = 1'b0;
      if (last) begin
         if (ok) model_byte(b, cyc);
         else    model_err(1);
      end
      repeat (HALF) @(negedge clk);
      PS2_clk = 1'b1;
   endtask

   function automatic logic [10:0] mk_frame(logic [7:0] b, bit bad_par, bit bad_stop);
      return {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
   endfunction

   task automatic send_frame(logic [7:0] b, bit bad_par = 0, bit bad_stop = 0);
      logic [10:0] f;
      f = mk_frame(b, bad_par, bad_stop);
      for (int i = 0; i < 11; i++) drive_bit(f[i], i == 10, b, !(bad_par || bad_stop));
      PS2_data = 1'b1;
      repeat (2 * HALF) @(negedge clk);
   endtask

   task automatic send_partial(logic [7:0] b, int nbits);
      logic [10:0] f;
      f = mk_frame(b, 0, 0);
      for (int i = 0; i < nbits; i++) drive_bit(f[i], 0, b, 1);
      PS2_data = 1'b1;
   endtask

   task automatic do_timeout(int nbits);
      send_partial(8'h5A, nbits);
      model_err(1);
      repeat (TMO + 50) @(negedge clk);
   endtask

   task automatic start_err();
      PS2_data = 1'b1;
      repeat (HALF) @(negedge clk);
      model_err(0);
      PS2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      PS2_clk = 1'b1;
      repeat (2 * HALF) @(negedge clk);
   endtask

   task automatic glitch();
      repeat (HALF) @(negedge clk);
      PS2_clk = 1'b0;
      repeat (5) @(negedge clk);
      PS2_clk = 1'b1;
      repeat (HALF) @(negedge clk);
      chk("glitch_bitcnt", 32'(dut.r_bitcnt), 0);
   endtask

   task automatic chk_outputs_zero(string tag);
      chk({tag, "_keys"},  32'(key_pressed), 0);
      chk({tag, "_code"},  32'(scan_code), 0);
      chk({tag, "_ext"},   32'(scan_ext), 0);
      chk({tag, "_brk"},   32'(scan_break), 0);
      chk({tag, "_valid"}, 32'(scan_valid), 0);
      chk({tag, "_err"},   32'(frame_err), 0);
   endtask

   // Monitor: every strobe must match the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset && (scan_valid || frame_err)) begin
            chk("strobe_exclusive", 32'(scan_valid && frame_err), 0);
            if (q.size() == 0) chk("unexpected_strobe", {31'b0, scan_valid}, {31'b0, frame_err});
            else begin
               e = q.pop_front();
               chk("strobe_kind", {31'b0, frame_err}, {31'b0, e.is_err});
               chk("keys", 32'(key_pressed), 32'(e.keys));
               if (!e.is_err) begin
                  chk("code", 32'(scan_code), 32'(e.code));
                  chk("ext",  32'(scan_ext), 32'(e.ext));
                  chk("brk",  32'(scan_break), 32'(e.brk));
                  chk("latency", 32'(cyc - e.stop_cyc), FL + 3);
               end
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "simulation bound exceeded");
   end

   initial begin
      logic [7:0] b;
      int         sel;
      repeat (5) @(negedge clk);
      chk_outputs_zero("reset");
      reset = 1'b0;
      repeat (10) @(negedge clk);

      // Directed traffic: space, then the arrows and the plain keypad code.
      send_frame(8'h29); send_frame(8'hF0); send_frame(8'h29);
      send_frame(8'hE0); send_frame(8'h6B);
      send_frame(8'hE0); send_frame(8'h74);
      send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h6B);
      send_frame(8'h6B);
      // Parity error, then a good A. Stop and start bit errors.
      send_frame(8'h1C, 1, 0); send_frame(8'h1C);
      send_frame(8'h35, 0, 1);
      start_err();
      // Abandoned frame, then D.
      do_timeout(5); send_frame(8'h23);
      // Filter glitches between frames.
      glitch(); glitch(); glitch();
      // Repeated prefixes, then a typematic repeat.
      send_frame(8'hE0); send_frame(8'hE0); send_frame(8'hF0); send_frame(8'hF0); send_frame(8'h74);
      send_frame(8'h23); send_frame(8'h23);

      // Reset in mid-frame while space is held.
      send_frame(8'h29);
      chk("space_held", 32'(key_pressed), 32'(m_keys));
      send_partial(8'h29, 6);
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      chk_outputs_zero("midreset");
      m_keys = 5'b0; m_ext = 0; m_brk = 0;
      repeat (2 * HALF) @(negedge clk);
      send_frame(8'h29);

      // Random traffic.
      for (int it = 0; it < 60; it++) begin
         sel = $urandom_range(0, 19);
         case (sel)
            0, 1, 2, 3, 4, 5, 6: send_frame(kcode[$urandom_range(0, 4)]);
            7, 8:       send_frame(8'hE0);
            9, 10:      send_frame(8'hF0);
            11, 12, 13: begin b = 8'($urandom); send_frame(b); end
            14:         begin b = 8'($urandom); send_frame(b, 1, 0); end
            15:         begin b = 8'($urandom); send_frame(b, 0, 1); end
            16:         start_err();
            17:         glitch();
            18:         if (it % 4 == 2) do_timeout($urandom_range(1, 10)); else send_frame(8'h29);
            default:    send_frame(8'h1C);
         endcase
      end

      repeat (200) @(negedge clk);
      chk("queue_drained", 32'(q.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
